// File: rtl/ycontrol_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and owns the PC.
// Define YCTRL_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module ycontrol_fsm #(
  parameter logic [31:0] RESET_PC = 32'h28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] jTarget,
  input  logic [31:0] PCp4,
  output logic [31:0] PCin,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic        r_illegal;
  logic [31:0] w_pc_next;
  logic        w_complete;
  logic        w_retire;

  logic [6:0] w_opcode;
  logic       w_is_r, w_is_load, w_is_i, w_is_store, w_is_branch, w_is_jal, w_legal;
  logic       w_unused_ins;

  assign w_opcode     = ins[6:0];
  assign w_is_r       = (w_opcode == OPC_R);
  assign w_is_load    = (w_opcode == OPC_LOAD);
  assign w_is_i       = (w_opcode == OPC_I);
  assign w_is_store   = (w_opcode == OPC_STORE);
  assign w_is_branch  = (w_opcode == OPC_BRANCH);
  assign w_is_jal     = (w_opcode == OPC_JAL);
  assign w_legal      = w_is_r | w_is_load | w_is_i | w_is_store | w_is_branch | w_is_jal;
  assign w_unused_ins = &{1'b0, ins[31:7]};

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (w_is_load || w_is_store)         w_next = S_MEM;
        else if (w_is_r || w_is_i || w_is_jal) w_next = S_WB;
        else                                  w_next = S_FETCH;
      end
      S_MEM:    w_next = w_is_load ? S_WB : S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // The PC only moves on the edge that closes an instruction back into FETCH.
  assign w_complete = (r_state != S_FETCH) && (w_next == S_FETCH);
  assign w_retire   = w_complete && w_legal &&
                      ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

  always_comb begin
    w_pc_next = PCp4;
    if (w_is_branch && zero) w_pc_next = r_pc + (imm << 1);
    else if (w_is_jal)       w_pc_next = r_pc + (jTarget << 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (r_state == S_DECODE) && !w_legal;
      if (w_complete) r_pc <= w_pc_next;
    end
  end

`ifdef YCTRL_INSTRET_EN
  logic [31:0] r_instret;
  always_ff @(posedge clk) begin
    if (reset)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end
  assign instret = r_instret;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign instret = '0;
`endif

  assign PCin     = r_pc;
  assign state    = r_state;
  assign illegal  = r_illegal;
  assign ALUSrc   = (r_state == S_FETCH) ? 1'b1 : !(w_is_r || w_is_branch);
  assign op       = w_is_branch ? 3'b110 : 3'b010;
  assign MemRead  = (r_state == S_MEM) && w_is_load;
  assign MemWrite = (r_state == S_MEM) && w_is_store;
  assign RegWrite = (r_state == S_WB);
  assign Mem2Reg  = (r_state == S_WB) && w_is_load;

endmodule

// File: tb/tb_ycontrol_fsm.sv
// Scoreboard bench for ycontrol_fsm: a driver issues instructions and queues the expected outcome;
// a negedge monitor collects the observed state path and strobes and compares on each return to FETCH.
module tb_ycontrol_fsm;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = '0, imm = '0, jTarget = '0, PCp4 = '0;
  logic        zero = 1'b0;
  logic [31:0] PCin, instret;
  logic        RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, illegal;
  logic [2:0]  op, state;

  ycontrol_fsm #(.RESET_PC(32'h28)) dut (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .imm(imm), .jTarget(jTarget),
    .PCp4(PCp4), .PCin(PCin), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg),
    .MemRead(MemRead), .MemWrite(MemWrite), .op(op), .state(state), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seq;
    logic [31:0] pc_before;
    logic [31:0] pc_after;
    logic [31:0] instret;
    int          rw, mr, mw, m2r;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0, n_pass = 0, n_txn = 0;
  logic [31:0] m_pc = 32'h28;
  logic [31:0] m_instret = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver + reference model ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_pc = 32'h28;
    m_instret = '0;
  endtask

  // abort_k: -1 run to completion, -2 abort at a random point, >=0 abort after that many edges
  task automatic issue(input logic [31:0] i_ins, input logic i_zero, input logic [31:0] i_imm,
                       input logic [31:0] i_jt, input int abort_k);
    exp_t       e;
    int         path[$];
    int         k;
    logic [6:0] opc;
    opc = i_ins[6:0];
    case (opc)
      7'h33, 7'h13, 7'h6F: path = '{0, 1, 2, 4};
      7'h03:               path = '{0, 1, 2, 3, 4};
      7'h23:               path = '{0, 1, 2, 3};
      7'h63:               path = '{0, 1, 2};
      default:             path = '{0, 1};
    endcase
    e.seq = '0;
    foreach (path[j]) e.seq = (e.seq << 3) | 32'(path[j]);
    e.ill = (path.size() == 2);
    e.rw  = (path[path.size()-1] == 4) ? 1 : 0;
    e.mr  = (opc == 7'h03) ? 1 : 0;
    e.mw  = (opc == 7'h23) ? 1 : 0;
    e.m2r = (opc == 7'h03) ? 1 : 0;
    e.pc_before = m_pc;
    if (opc == 7'h63 && i_zero) e.pc_after = m_pc + (i_imm << 1);
    else if (opc == 7'h6F)      e.pc_after = m_pc + (i_jt << 2);
    else                        e.pc_after = m_pc + 32'd4;
`ifdef YCTRL_INSTRET_EN
    e.instret = e.ill ? m_instret : m_instret + 32'd1;
`else
    e.instret = '0;
`endif
    ins = i_ins; zero = i_zero; imm = i_imm; jTarget = i_jt; PCp4 = m_pc + 32'd4;
    if (abort_k == -1) begin
      sb.push_back(e);
      repeat (path.size()) @(posedge clk);
      #1;
      m_pc = e.pc_after;
      m_instret = e.ill ? m_instret : m_instret + 32'd1;
    end else begin
      k = (abort_k == -2) ? $urandom_range(0, path.size() - 1) : abort_k;
      repeat (k) @(posedge clk);
      #1;
      do_reset();
    end
  endtask

  // ---------------- monitor ----------------
  logic [31:0] o_seq = '0;
  int          o_rw = 0, o_mr = 0, o_mw = 0, o_m2r = 0, o_ill = 0, o_bad = 0;
  logic [2:0]  prev = 3'd0;
  bit          chk_rst = 1'b0;

  task automatic start_new();
    o_seq = '0; o_rw = 0; o_mr = 0; o_mw = 0; o_m2r = 0; o_ill = 0; o_bad = 0;
  endtask

  task automatic accumulate();
    logic [2:0] exp_op;
    logic       exp_src;
    o_seq = (o_seq << 3) | 32'(state);
    o_rw  += int'(RegWrite);
    o_mr  += int'(MemRead);
    o_mw  += int'(MemWrite);
    o_m2r += int'(Mem2Reg);
    if (state != 3'd0 && illegal) o_ill++;
    exp_op  = (ins[6:0] == 7'h63) ? 3'b110 : 3'b010;
    exp_src = (state == 3'd0) ? 1'b1 : !(ins[6:0] == 7'h33 || ins[6:0] == 7'h63);
    if (op !== exp_op) o_bad++;
    if (ALUSrc !== exp_src) o_bad++;
    if (MemRead && MemWrite) o_bad++;
    if (state == 3'd0 && (RegWrite || MemRead || MemWrite || Mem2Reg)) o_bad++;
    if (sb.size() > 0 && PCin !== sb[0].pc_before) o_bad++;
  endtask

  task automatic complete();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_completion: got completion at pc %h required none", PCin);
      return;
    end
    e = sb.pop_front();
    n_txn++;
    $display("txn %0d ins=%h seq=%h pc %h->%h instret=%0d", n_txn, ins, o_seq, e.pc_before, PCin, instret);
    check("state_path", o_seq, e.seq);
    check("pc_after", PCin, e.pc_after);
    check("regwrite_cycles", o_rw, e.rw);
    check("memread_cycles", o_mr, e.mr);
    check("memwrite_cycles", o_mw, e.mw);
    check("mem2reg_cycles", o_m2r, e.m2r);
    check("illegal_pulse", {31'd0, illegal}, {31'd0, e.ill});
    check("illegal_stray", o_ill, 0);
    check("ctrl_violations", o_bad, 0);
    check("instret", instret, e.instret);
  endtask

  always @(negedge clk) begin
    if (chk_rst) begin
      chk_rst = 1'b0;
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_pc", PCin, 32'h28);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
      check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      start_new();
    end else if (state == 3'd0 && prev != 3'd0) begin
      complete();
      start_new();
    end
    accumulate();
    prev = state;
    if (reset) chk_rst = 1'b1;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    int          sel;
    logic [6:0]  legal_ops [6];
    legal_ops = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    issue(32'h00B50533, 1'b0, 32'd0, 32'd0, -1);   // R-type, 28->2C
    issue(32'h0002A303, 1'b0, 32'd0, 32'd0, -1);   // load, 2C->30
    do_reset();
    issue(32'h00B50463, 1'b1, 32'd4, 32'd0, -1);   // taken branch, 28->30
    do_reset();
    issue(32'h00B50463, 1'b0, 32'd4, 32'd0, -1);   // not taken, 28->2C
    do_reset();
    issue(32'h0080006F, 1'b0, 32'd0, 32'd2, -1);   // jal, 28->30
    issue(32'h0000007F, 1'b0, 32'd0, 32'd0, -1);   // illegal opcode
    issue(32'h0062A023, 1'b0, 32'd0, 32'd0, 3);    // store aborted in MEM
    issue(32'h00B50533, 1'b0, 32'd0, 32'd0, -1);
    issue(32'h00150513, 1'b0, 32'd0, 32'd0, -1);
    issue(32'h0002A303, 1'b0, 32'd0, 32'd0, -1);   // third retired: instret=3
    issue(32'hFFFFF063, 1'b1, 32'h8000_0000, 32'd0, -1); // branch offset wraps PC

    for (int n = 0; n < 250; n++) begin
      r = $urandom();
      sel = $urandom_range(0, 6);
      if (sel == 6) begin
        opc = 7'h7F;
        while (opc == 7'h33 || opc == 7'h03 || opc == 7'h13 || opc == 7'h23 ||
               opc == 7'h63 || opc == 7'h6F)
          opc = 7'($urandom_range(0, 127));
        opc = (opc == 7'h7F) ? 7'($urandom_range(0, 2)) : opc;
      end else begin
        opc = legal_ops[sel];
      end
      issue({r[31:7], opc}, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
            ($urandom_range(0, 9) == 0) ? -2 : -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
